// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer for the pixel array and column ADC: frame reset, counted exposure, then per-row ADC reset/convert/read.
// Optional ADC watchdog is built when PIXEL_SEQ_ADC_TIMEOUT_EN is defined; otherwise error is tied low.
module pixel_seq_ctrl #(
    parameter int ROWS    = 4,
    parameter int EXP_W   = 8,
    parameter int TIMEOUT = 64,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             state_reset,
    input  logic             start,
    input  logic [EXP_W-1:0] expose_cycles,
    input  logic             ADC_finished,
    output logic             frame_reset,
    output logic             expose_enable,
    output logic             ADC_reset,
    output logic             convert,
    output logic             read,
    output logic [ROW_W-1:0] read_row,
    output logic             busy,
    output logic             frame_done,
    output logic             error
);

    if (ROWS < 1 || EXP_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("pixel_seq_ctrl: ROWS, EXP_W and TIMEOUT must all be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAMERESET,
        S_EXPOSE,
        S_ADCRESET,
        S_CONVERT,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    state_t           state_reg, state_next;
    logic [EXP_W-1:0] exp_len_reg, exp_len_next;
    logic [EXP_W-1:0] exp_cnt_reg, exp_cnt_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [ROW_W-1:0] read_row_reg, read_row_next;
    logic             frame_reset_reg, frame_reset_next;
    logic             expose_enable_reg, expose_enable_next;
    logic             adc_reset_reg, adc_reset_next;
    logic             convert_reg, convert_next;
    logic             read_reg, read_next;
    logic             busy_reg, busy_next;
    logic             frame_done_reg, frame_done_next;

`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_reg, wd_next;
    logic            error_reg, error_next;
`endif

    always_comb begin
        state_next   = state_reg;
        exp_len_next = exp_len_reg;
        exp_cnt_next = exp_cnt_reg;
        row_next     = row_reg;
`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
        wd_next      = wd_reg;
        error_next   = error_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                row_next     = '0;
                exp_cnt_next = '0;
                if (start) begin
                    state_next   = S_FRAMERESET;
                    exp_len_next = (expose_cycles == '0) ? EXP_ONE : expose_cycles;
`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
                    error_next   = 1'b0;
`endif
                end
            end
            S_FRAMERESET: begin
                state_next   = S_EXPOSE;
                exp_cnt_next = '0;
            end
            S_EXPOSE: begin
                // Counts 0..exp_len-1, so a full-scale length never wraps the counter.
                if (exp_cnt_reg == exp_len_reg - EXP_ONE) begin
                    state_next = S_ADCRESET;
                    row_next   = '0;
                end else begin
                    exp_cnt_next = exp_cnt_reg + EXP_ONE;
                end
            end
            S_ADCRESET: begin
                state_next = S_CONVERT;
`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
                wd_next    = '0;
`endif
            end
            S_CONVERT: begin
                // A finish arriving on the expiry cycle still counts as a good conversion.
                if (ADC_finished) begin
                    state_next = S_READ;
`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
                end else if (wd_reg == WD_LAST) begin
                    state_next = S_IDLE;
                    error_next = 1'b1;
                end else begin
                    wd_next = wd_reg + WD_ONE;
`endif
                end
            end
            S_READ: begin
                if (row_reg == ROW_LAST) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ADCRESET;
                    row_next   = row_reg + ROW_ONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        frame_reset_next   = (state_next == S_FRAMERESET);
        expose_enable_next = (state_next == S_EXPOSE);
        adc_reset_next     = (state_next == S_ADCRESET);
        convert_next       = (state_next == S_CONVERT);
        read_next          = (state_next == S_READ);
        frame_done_next    = (state_next == S_DONE);
        busy_next          = (state_next != S_IDLE);

        read_row_next = read_row_reg;
        if (state_next == S_READ) begin
            read_row_next = row_reg;
        end else if (state_next == S_IDLE) begin
            read_row_next = '0;
        end
    end

    always_ff @(posedge clk or posedge state_reset) begin
        if (state_reset) begin
            state_reg         <= S_IDLE;
            exp_len_reg       <= '0;
            exp_cnt_reg       <= '0;
            row_reg           <= '0;
            read_row_reg      <= '0;
            frame_reset_reg   <= 1'b0;
            expose_enable_reg <= 1'b0;
            adc_reset_reg     <= 1'b0;
            convert_reg       <= 1'b0;
            read_reg          <= 1'b0;
            busy_reg          <= 1'b0;
            frame_done_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            exp_len_reg       <= exp_len_next;
            exp_cnt_reg       <= exp_cnt_next;
            row_reg           <= row_next;
            read_row_reg      <= read_row_next;
            frame_reset_reg   <= frame_reset_next;
            expose_enable_reg <= expose_enable_next;
            adc_reset_reg     <= adc_reset_next;
            convert_reg       <= convert_next;
            read_reg          <= read_next;
            busy_reg          <= busy_next;
            frame_done_reg    <= frame_done_next;
        end
    end

`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
    always_ff @(posedge clk or posedge state_reset) begin
        if (state_reset) begin
            wd_reg    <= '0;
            error_reg <= 1'b0;
        end else begin
            wd_reg    <= wd_next;
            error_reg <= error_next;
        end
    end

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    assign frame_reset   = frame_reset_reg;
    assign expose_enable = expose_enable_reg;
    assign ADC_reset     = adc_reset_reg;
    assign convert       = convert_reg;
    assign read          = read_reg;
    assign read_row      = read_row_reg;
    assign busy          = busy_reg;
    assign frame_done    = frame_done_reg;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed bench for pixel_seq_ctrl: table of frames with hand-computed pulse widths plus
// hand-written sequences for reset, held start, mid-frame abort and the ADC watchdog.
module tb_pixel_seq_ctrl;
    localparam int ROWS    = 4;
    localparam int EXP_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam int C_IDLE = 0, C_FR = 1, C_EX = 2, C_AR = 3, C_CV = 4, C_RD = 5, C_DN = 6, C_MULTI = 7;

    logic             clk = 1'b0;
    logic             state_reset;
    logic             start;
    logic [EXP_W-1:0] expose_cycles;
    logic             ADC_finished;
    logic             frame_reset, expose_enable, ADC_reset, convert, read;
    logic [ROW_W-1:0] read_row;
    logic             busy, frame_done, error;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int done_want = 0;

    always #5 clk = ~clk;

    pixel_seq_ctrl #(.ROWS(ROWS), .EXP_W(EXP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .state_reset(state_reset), .start(start), .expose_cycles(expose_cycles),
        .ADC_finished(ADC_finished), .frame_reset(frame_reset), .expose_enable(expose_enable),
        .ADC_reset(ADC_reset), .convert(convert), .read(read), .read_row(read_row),
        .busy(busy), .frame_done(frame_done), .error(error)
    );

    task automatic check_eq(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    function automatic int classify();
        int n;
        n = int'(frame_reset) + int'(expose_enable) + int'(ADC_reset) + int'(convert)
            + int'(read) + int'(frame_done);
        if (n > 1) return C_MULTI;
        if (frame_reset) return C_FR;
        if (expose_enable) return C_EX;
        if (ADC_reset) return C_AR;
        if (convert) return C_CV;
        if (read) return C_RD;
        if (frame_done) return C_DN;
        return C_IDLE;
    endfunction

    function automatic int all_outs();
        return int'({frame_reset, expose_enable, ADC_reset, convert, read, busy, frame_done, error, read_row});
    endfunction

    // Runs one frame from an idle negedge; records each output pulse (kind, width, read_row) and
    // compares against the sequence expected for the given exposure and conversion widths.
    task automatic run_frame(input string tag, input int expv, input int conv_len, input bit fin_hold,
                             input int want_ex, input int want_cv);
        int got_c[$], got_l[$], got_r[$];
        int exp_c[$], exp_l[$], exp_r[$];
        int code, prev, cv_cnt;
        bit ended, multi, err_hi;
        exp_c.push_back(C_FR); exp_l.push_back(1);       exp_r.push_back(0);
        exp_c.push_back(C_EX); exp_l.push_back(want_ex); exp_r.push_back(0);
        for (int r = 0; r < ROWS; r++) begin
            exp_c.push_back(C_AR); exp_l.push_back(1);       exp_r.push_back((r == 0) ? 0 : r - 1);
            exp_c.push_back(C_CV); exp_l.push_back(want_cv); exp_r.push_back((r == 0) ? 0 : r - 1);
            exp_c.push_back(C_RD); exp_l.push_back(1);       exp_r.push_back(r);
        end
        exp_c.push_back(C_DN); exp_l.push_back(1); exp_r.push_back(ROWS - 1);
        done_want++;

        expose_cycles = EXP_W'(expv);
        start = 1'b1;
        ADC_finished = fin_hold;
        @(negedge clk);
        start = 1'b0;
        prev = -1; cv_cnt = 0; ended = 1'b0; multi = 1'b0; err_hi = 1'b0;
        for (int cyc = 0; cyc < 2000 && !ended; cyc++) begin
            if (!busy) begin
                ended = 1'b1;
            end else begin
                code = classify();
                if (code == C_MULTI) multi = 1'b1;
                if (error) err_hi = 1'b1;
                if (code == C_DN) done_seen++;
                if (code == prev) begin
                    got_l[got_l.size() - 1]++;
                end else begin
                    got_c.push_back(code); got_l.push_back(1); got_r.push_back(int'(read_row));
                end
                prev = code;
                cv_cnt = (code == C_CV) ? cv_cnt + 1 : 0;
                ADC_finished = fin_hold || (cv_cnt == conv_len);
                @(negedge clk);
            end
        end
        ADC_finished = 1'b0;
        check_eq({tag, " ended"}, int'(ended), 1);
        check_eq({tag, " segments"}, got_c.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            total++;
            if (got_c[i] != exp_c[i] || got_l[i] != exp_l[i] || got_r[i] != exp_r[i]) begin
                bad++;
                $display("FAIL %s seg%0d: got kind=%0d len=%0d row=%0d want kind=%0d len=%0d row=%0d",
                         tag, i, got_c[i], got_l[i], got_r[i], exp_c[i], exp_l[i], exp_r[i]);
            end
        end
        check_eq({tag, " onehot"}, int'(multi), 0);
        check_eq({tag, " error during frame"}, int'(err_hi), 0);
        check_eq({tag, " idle outputs"}, all_outs(), 0);
        $display("frame %s: expose=%0d conv=%0d segments=%0d", tag, expv, conv_len, got_c.size());
    endtask

    typedef struct {
        int expv;
        int conv_len;
        bit hold;
        int want_ex;
        int want_cv;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        int fr_rises, dn, gap, reads, cv_cnt, cv_row1, code, dn_cnt, busy_cnt;
        bit prev_fr, fin_loop;
        vecs[0] = '{10, 3, 1'b0, 10, 3};
        vecs[1] = '{0, 3, 1'b0, 1, 3};
        vecs[2] = '{1, 1, 1'b0, 1, 1};
        vecs[3] = '{5, 4, 1'b1, 5, 1};
        vecs[4] = '{255, 2, 1'b0, 255, 2};
        vecs[5] = '{2, 5, 1'b0, 2, 5};

        // Reset and idle behaviour
        state_reset = 1'b1; start = 1'b0; ADC_finished = 1'b0; expose_cycles = '0;
        repeat (3) @(negedge clk);
        check_eq("outputs during reset", all_outs(), 0);
        state_reset = 1'b0;
        @(negedge clk);
        check_eq("outputs after reset", all_outs(), 0);
        ADC_finished = 1'b1;
        @(negedge clk);
        ADC_finished = 1'b0;
        @(negedge clk);
        check_eq("outputs after stray ADC_finished", all_outs(), 0);
        $display("reset: outputs=%0d", all_outs());

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].expv, vecs[i].conv_len, vecs[i].hold,
                      vecs[i].want_ex, vecs[i].want_cv);
        end

        // start held high: one frame, one idle cycle, exactly one more frame
        start = 1'b1; expose_cycles = 8'd3; ADC_finished = 1'b1;
        fr_rises = 0; dn = 0; gap = 0; prev_fr = 1'b0; fin_loop = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin_loop; cyc++) begin
            if (dn == 2 && !busy) begin
                fin_loop = 1'b1;
            end else begin
                if (frame_reset && !prev_fr) fr_rises++;
                prev_fr = frame_reset;
                if (frame_done) dn++;
                if (dn == 1 && !busy) gap++;
                if (fr_rises == 2) start = 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0; ADC_finished = 1'b0;
        done_seen += dn; done_want += 2;
        check_eq("held start loop ended", int'(fin_loop), 1);
        check_eq("held start frame_reset pulses", fr_rises, 2);
        check_eq("held start frame_done pulses", dn, 2);
        check_eq("held start idle gap", gap, 1);
        $display("held start: frames=%0d gap=%0d", fr_rises, gap);

        // Asynchronous abort during row 2 conversion
        expose_cycles = 8'd3; start = 1'b1; ADC_finished = 1'b0;
        @(negedge clk);
        start = 1'b0;
        reads = 0; cv_cnt = 0; fin_loop = 1'b0;
        for (int cyc = 0; cyc < 500 && !fin_loop; cyc++) begin
            code = classify();
            if (code == C_RD) reads++;
            if (code == C_CV && reads == 2) begin
                fin_loop = 1'b1;
            end else begin
                cv_cnt = (code == C_CV) ? cv_cnt + 1 : 0;
                ADC_finished = (cv_cnt == 3);
                @(negedge clk);
            end
        end
        check_eq("abort reached row2 convert", int'(fin_loop), 1);
        ADC_finished = 1'b0;
        #2 state_reset = 1'b1;
        #1 check_eq("abort outputs without clock", all_outs(), 0);
        @(negedge clk);
        @(negedge clk);
        state_reset = 1'b0;
        dn_cnt = 0; busy_cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (frame_done) dn_cnt++;
            if (busy) busy_cnt++;
        end
        done_seen += dn_cnt;
        check_eq("abort no frame_done", dn_cnt, 0);
        check_eq("abort stays idle", busy_cnt, 0);
        $display("abort: done=%0d busy=%0d", dn_cnt, busy_cnt);
        run_frame("after_abort", 4, 2, 1'b0, 4, 2);

        // Row 1 conversion never finishes
        expose_cycles = 8'd2; start = 1'b1; ADC_finished = 1'b0;
        @(negedge clk);
        start = 1'b0;
        reads = 0; cv_cnt = 0; cv_row1 = 0; dn_cnt = 0; fin_loop = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin_loop; cyc++) begin
            if (!busy) begin
                fin_loop = 1'b1;
            end else begin
                code = classify();
                if (code == C_RD) reads++;
                if (code == C_DN) dn_cnt++;
                if (code == C_CV && reads == 1) cv_row1++;
                cv_cnt = (code == C_CV) ? cv_cnt + 1 : 0;
                ADC_finished = (reads == 0) && (cv_cnt == 2);
                @(negedge clk);
            end
        end
        ADC_finished = 1'b0;
        done_seen += dn_cnt;
        check_eq("stall no frame_done", dn_cnt, 0);
        check_eq("stall reads issued", reads, 1);
`ifdef PIXEL_SEQ_ADC_TIMEOUT_EN
        check_eq("timeout returned idle", int'(fin_loop), 1);
        check_eq("timeout convert width", cv_row1, TIMEOUT);
        check_eq("timeout error set", int'(error), 1);
        repeat (3) @(negedge clk);
        check_eq("timeout error sticky", int'(error), 1);
        check_eq("timeout busy low", int'(busy), 0);
        $display("timeout: convert=%0d error=%0d", cv_row1, error);
        run_frame("clears_error", 3, 2, 1'b0, 3, 2);
`else
        check_eq("stall still busy", int'(fin_loop), 0);
        check_eq("stall convert held", int'(convert), 1);
        check_eq("stall error low", int'(error), 0);
        check_eq("stall convert width", cv_row1, 300 - 8);
        $display("stall: convert=%0d error=%0d", cv_row1, error);
        #2 state_reset = 1'b1;
        @(negedge clk);
        state_reset = 1'b0;
        @(negedge clk);
        run_frame("recovery", 3, 2, 1'b0, 3, 2);
`endif

        // Back-to-back frames with random exposure
        for (int i = 0; i < 20; i++) begin
            int v, c;
            v = int'($urandom_range(0, 255));
            c = int'($urandom_range(1, 4));
            run_frame($sformatf("rand%0d", i), v, c, 1'b0, (v == 0) ? 1 : v, c);
        end

        check_eq("frame_done count", done_seen, done_want);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
